// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: per-entry valid/tag, 2-bit saturating counter and target.
// Combinational IF lookup, EX-stage resolve with same-cycle flush/redirect and perf counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = PC_W - IDX_W - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_IF,
  output logic            predTaken_IF,
  output logic [PC_W-1:0] predTarget_IF,
  input  logic            branch_EX,
  input  logic            stall_EX,
  input  logic [PC_W-1:0] pc_EX,
  input  logic [PC_W-1:0] target_EX,
  input  logic            taken_EX,
  input  logic            predTaken_EX,
  input  logic [PC_W-1:0] predTarget_EX,
  output logic            flush,
  output logic [PC_W-1:0] redirectPC,
  output logic [15:0]     branchCnt,
  output logic [15:0]     mispredCnt
);

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [1:0]       r_ctr   [ENTRIES];
  logic [PC_W-1:0]  r_tgt   [ENTRIES];
  logic [15:0]      r_branch_cnt;
  logic [15:0]      r_mispred_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_resolve;
  logic             w_mispredict;
  logic             w_unused;

  assign w_unused = ^{pc_IF[1:0], pc_EX[1:0]};

  // Fetch-side lookup reads the table as it stood before this cycle's update.
  assign w_if_idx      = pc_IF[IDX_W+1:2];
  assign w_if_tag      = pc_IF[PC_W-1:IDX_W+2];
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign predTaken_IF  = w_if_hit && r_ctr[w_if_idx][1];
  assign predTarget_IF = w_if_hit ? r_tgt[w_if_idx] : pc_IF + PC_W'(4);

  assign w_ex_idx = pc_EX[IDX_W+1:2];
  assign w_ex_tag = pc_EX[PC_W-1:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // Gating with reset keeps flush low for the whole time reset is held.
  assign w_resolve    = branch_EX && !stall_EX && reset;
  assign w_mispredict = (predTaken_EX != taken_EX) ||
                        (predTaken_EX && taken_EX && (predTarget_EX != target_EX));
  assign flush        = w_resolve && w_mispredict;
  assign redirectPC   = (flush && taken_EX) ? target_EX : pc_EX + PC_W'(4);

  assign branchCnt  = r_branch_cnt;
  assign mispredCnt = r_mispred_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_ctr[i]   <= 2'b01;
        r_tgt[i]   <= '0;
      end
    end else if (w_resolve) begin
      if (w_ex_hit) begin
        if (taken_EX) begin
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          r_tgt[w_ex_idx] <= target_EX;
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (taken_EX) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_ctr[w_ex_idx]   <= 2'b10;
        r_tgt[w_ex_idx]   <= target_EX;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve && (r_branch_cnt != 16'hFFFF))
        r_branch_cnt <= r_branch_cnt + 16'd1;
      if (flush && (r_mispred_cnt != 16'hFFFF))
        r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor: a table model predicts each cycle's outputs,
// a negedge monitor pops the expectation queue and compares.
module tb_branch_predictor;

  localparam int PC_W = 32;
  localparam int ENT  = 64;

  logic            clk;
  logic            reset;
  logic [PC_W-1:0] pc_IF;
  logic            predTaken_IF;
  logic [PC_W-1:0] predTarget_IF;
  logic            branch_EX;
  logic            stall_EX;
  logic [PC_W-1:0] pc_EX;
  logic [PC_W-1:0] target_EX;
  logic            taken_EX;
  logic            predTaken_EX;
  logic [PC_W-1:0] predTarget_EX;
  logic            flush;
  logic [PC_W-1:0] redirectPC;
  logic [15:0]     branchCnt;
  logic [15:0]     mispredCnt;

  branch_predictor #(.ENTRIES(ENT), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .pc_IF(pc_IF), .predTaken_IF(predTaken_IF),
    .predTarget_IF(predTarget_IF), .branch_EX(branch_EX), .stall_EX(stall_EX),
    .pc_EX(pc_EX), .target_EX(target_EX), .taken_EX(taken_EX),
    .predTaken_EX(predTaken_EX), .predTarget_EX(predTarget_EX), .flush(flush),
    .redirectPC(redirectPC), .branchCnt(branchCnt), .mispredCnt(mispredCnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic [31:0] rpc;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model: one record per table slot, counter kept as an integer 0..3
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  int          m_ctr   [ENT];
  int unsigned m_tgt   [ENT];
  int          m_bc;
  int          m_mc;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic int m_index(int unsigned pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int unsigned m_tagof(int unsigned pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit m_hit(int unsigned pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
  endfunction

  // driver: apply one cycle of inputs just after the edge, push the expected response
  task automatic drive(input bit rst, input int unsigned pcif, input bit br, input bit st,
                       input int unsigned pcex, input int unsigned tgex, input bit tk,
                       input bit ptk, input int unsigned ptg);
    exp_t e;
    bit resolve, mis, hit;
    int ix;
    @(posedge clk);
    #1;
    reset = rst; pc_IF = pcif; branch_EX = br; stall_EX = st; pc_EX = pcex;
    target_EX = tgex; taken_EX = tk; predTaken_EX = ptk; predTarget_EX = ptg;
    if (!rst) model_reset();
    e.pt   = m_hit(pcif) && (m_ctr[m_index(pcif)] >= 2);
    e.ptgt = m_hit(pcif) ? m_tgt[m_index(pcif)] : pcif + 4;
    resolve = rst && br && !st;
    mis     = (ptk != tk) || (ptk && tk && (ptg != tgex));
    e.fl    = resolve && mis;
    e.rpc   = (e.fl && tk) ? tgex : pcex + 4;
    e.bc    = 16'(m_bc);
    e.mc    = 16'(m_mc);
    exp_q.push_back(e);
    if (resolve) begin
      ix  = m_index(pcex);
      hit = m_hit(pcex);
      if (hit && tk) begin
        m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
        m_tgt[ix] = tgex;
      end else if (hit) begin
        m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
      end else if (tk) begin
        m_valid[ix] = 1; m_tag[ix] = m_tagof(pcex); m_ctr[ix] = 2; m_tgt[ix] = tgex;
      end
      m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
      if (e.fl) m_mc = (m_mc < 65535) ? m_mc + 1 : 65535;
    end
  endtask

  task automatic idle(input int unsigned pcif);
    drive(1, pcif, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic resolve_br(input int unsigned pcex, input int unsigned tgex, input bit tk,
                            input bit ptk, input int unsigned ptg);
    drive(1, 32'h40, 1, 0, pcex, tgex, tk, ptk, ptg);
  endtask

  // monitor: one response per cycle, compared on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("predTaken_IF",  32'(predTaken_IF), 32'(e.pt));
      chk("predTarget_IF", predTarget_IF, e.ptgt);
      chk("flush",         32'(flush), 32'(e.fl));
      chk("redirectPC",    redirectPC, e.rpc);
      chk("branchCnt",     32'(branchCnt), 32'(e.bc));
      chk("mispredCnt",    32'(mispredCnt), 32'(e.mc));
    end
  end

  initial begin
    int unsigned pa, pb, tg;
    bit tk, ptk;
    reset = 1'b0; pc_IF = 32'h40; branch_EX = 0; stall_EX = 0; pc_EX = 0;
    target_EX = 0; taken_EX = 0; predTaken_EX = 0; predTarget_EX = 0;
    model_reset();

    // held in reset with a mispredicting branch presented
    repeat (3) drive(0, 32'h40, 1, 0, 32'h40, 32'h80, 1, 0, 32'h0);
    idle(32'h40);
    @(negedge clk);
    chk("rst_pred_tgt", predTarget_IF, 32'h44);
    chk("rst_mispred",  32'(mispredCnt), 32'h0);

    resolve_br(32'h40, 32'h80, 1, 0, 32'h0);
    @(negedge clk);
    chk("alloc_flush",    32'(flush), 32'h1);
    chk("alloc_redirect", redirectPC, 32'h80);
    idle(32'h40);
    @(negedge clk);
    chk("alloc_pred",   32'(predTaken_IF), 32'h1);
    chk("alloc_target", predTarget_IF, 32'h80);

    // counter walk 10 -> 11 -> 11 -> 11 -> 10 -> 01
    repeat (3) resolve_br(32'h40, 32'h80, 1, 1, 32'h80);
    resolve_br(32'h40, 32'h44, 0, 1, 32'h80);
    resolve_br(32'h40, 32'h44, 0, 1, 32'h80);
    idle(32'h40);
    @(negedge clk);
    chk("weak_nt_pred", 32'(predTaken_IF), 32'h0);

    // wrong target while predicted taken
    resolve_br(32'h40, 32'h80, 1, 0, 32'h44);
    resolve_br(32'h40, 32'h90, 1, 1, 32'h80);
    @(negedge clk);
    chk("tgt_redirect", redirectPC, 32'h90);
    idle(32'h40);
    @(negedge clk);
    chk("tgt_update", predTarget_IF, 32'h90);

    // stalled mispredict, then released
    drive(1, 32'h40, 1, 1, 32'h40, 32'h44, 0, 1, 32'h90);
    drive(1, 32'h40, 1, 1, 32'h40, 32'h44, 0, 1, 32'h90);
    drive(1, 32'h40, 1, 0, 32'h40, 32'h44, 0, 1, 32'h90);

    // alias on the same index evicts the original branch
    resolve_br(32'h140, 32'h200, 1, 0, 32'h0);
    idle(32'h40);
    @(negedge clk);
    chk("alias_pred", 32'(predTaken_IF), 32'h0);
    idle(32'h140);

    // reset in the middle of a pending update
    drive(0, 32'h140, 1, 0, 32'h140, 32'h300, 1, 0, 32'h0);
    drive(1, 32'h140, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    // random traffic over a small PC pool so aliasing and hits are frequent
    for (int n = 0; n < 600; n++) begin
      pa  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      pb  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 9) == 0) pb = 32'hFFFF_FFFC;
      tg  = $urandom_range(0, 15) << 4;
      tk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        ptk = m_hit(pb) && (m_ctr[m_index(pb)] >= 2);
        drive(($urandom_range(0, 49) != 0), pa, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 4) == 0), pb, tg, tk, ptk,
              m_hit(pb) ? m_tgt[m_index(pb)] : pb + 4);
      end else begin
        drive(($urandom_range(0, 49) != 0), pa, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 4) == 0), pb, tg, tk, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) << 4);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 64, number of BHT/BTB entries (power of two); IDX_W = log2(ENTRIES).
REQ-002 Parameter: PC_W, default 32, program-counter width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-005 Port: pc_IF  input  PC_W  fetch PC for lookup.
REQ-006 Port: predTaken_IF  output  1  predicted taken for pc_IF.
REQ-007 Port: predTarget_IF  output  PC_W  predicted target for pc_IF.
REQ-008 Port: branch_EX  input  1  conditional branch (beq/bne) resolving in EX this cycle.
REQ-009 Port: stall_EX  input  1  EX stage held; suppresses update and flush.
REQ-010 Port: pc_EX, target_EX  input  PC_W each  PC and computed target of the EX branch.
REQ-011 Port: taken_EX  input  1  resolved outcome from the EX comparator.
REQ-012 Port: predTaken_EX, predTarget_EX  input  1 / PC_W  prediction carried down the pipe for this branch.
REQ-013 Port: flush  output  1  mispredict; squash IF/ID and redirect fetch.
REQ-014 Port: redirectPC  output  PC_W  correct next PC when flush=1.
REQ-015 Port: branchCnt, mispredCnt  output  16 each  performance counters.

Function
REQ-016 Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; each entry holds valid, tag, 2-bit counter, target.
REQ-017 Lookup is combinational: hit = valid && tag match; predTaken_IF = hit && ctr[1]; predTarget_IF = entry target on hit, else pc_IF+4.
REQ-018 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 Resolve cycle = branch_EX && !stall_EX; outside a resolve cycle flush=0 and no state changes except as in REQ-029.
REQ-020 Mispredict (combinational, same cycle) when: predTaken_EX != taken_EX, or predTaken_EX && taken_EX && predTarget_EX != target_EX.
REQ-021 flush = resolve && mispredict; redirectPC = target_EX if taken_EX, else pc_EX+4; redirectPC = pc_EX+4 when flush=0.
REQ-022 Update on resolve, hit: taken increments counter saturating at 11, not-taken decrements saturating at 00; taken also rewrites target.
REQ-023 Update on resolve, miss, taken: allocate (valid=1, tag, target_EX, counter=10), replacing any previous occupant.
REQ-024 Update on resolve, miss, not taken: no table change.
REQ-025 Same-index read and write in one cycle: IF lookup sees pre-update contents (no bypass); new value visible the following cycle.
REQ-026 branchCnt increments on every resolve; mispredCnt increments when flush=1; both saturate at 16'hFFFF.
REQ-027 Address arithmetic (pc+4) is modulo 2^PC_W.
REQ-028 Implementation 120-400 RTL lines; table in flops (async clear needed).

Reset
REQ-029 While reset=0: all valid bits 0, all counters 01, targets 0, branchCnt=mispredCnt=0; predTaken_IF=0, predTarget_IF=pc_IF+4; flush=0 regardless of EX inputs.
REQ-030 Reset asserted mid-operation discards any pending update; first edge after release performs normal operation.

Verification
REQ-031 After reset, pc_IF=0x40 -> predTaken_IF=0, predTarget_IF=0x44; counters 0.
REQ-032 Resolve pc_EX=0x40, target_EX=0x80, taken=1, predTaken_EX=0 -> flush=1, redirectPC=0x80; next cycle pc_IF=0x40 gives predTaken_IF=1, predTarget_IF=0x80, mispredCnt=1.
REQ-033 Same branch resolved taken 3 more times then not-taken twice -> counter path 10,11,11,11,10,01; predTaken_IF=0 after the second not-taken.
REQ-034 Predicted taken to 0x80, resolved taken to 0x90 -> flush=1, redirectPC=0x90, stored target becomes 0x90.
REQ-035 Resolve with stall_EX=1 and a mispredict -> flush=0, table and counters unchanged; same inputs with stall released -> flush=1.
REQ-036 Alias: pc 0x40 allocated, then pc 0x140 (same index, different tag) resolved taken -> pc_IF=0x40 now misses, predTaken_IF=0.
